mips_alu_bist: RTL and testbench

MIPS_ALU_BIST -- requirements
Module: mips_alu_bist

---
 rtl/mips_alu_bist_if.sv | 11 +
 rtl/mips_alu_bist.sv | 106 ++++++++++
 tb/tb_mips_alu_bist.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/mips_alu_bist_if.sv
// rtl/mips_alu_bist_if.sv - operand/result bus between the BIST engine and the MIPSALU under test
interface mips_alu_bist_if;
  logic [3:0]  ALUctl;
  logic [31:0] A;
  logic [31:0] B;
  logic [31:0] ALUOut;
  logic        Zero;

  modport master (output ALUctl, A, B, input ALUOut, Zero);
  modport slave  (input ALUctl, A, B, output ALUOut, Zero);
endinterface

// File: rtl/mips_alu_bist.sv
// rtl/mips_alu_bist.sv - LFSR-driven MIPSALU self-test with MISR signature compaction
module mips_alu_bist #(
  parameter int          NUM_VECTORS = 64,
  parameter logic [31:0] LFSR_SEED   = 32'hACE12468,
  parameter logic [31:0] GOLDEN_SIG  = 32'h00000000
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   abort,
  mips_alu_bist_if.master        alu,
  output logic                   busy,
  output logic                   done,
  output logic                   pass,
  output logic [31:0]            signature
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [15:0] LAST = 16'(NUM_VECTORS - 1);

  logic [1:0]  state;
  logic [31:0] lfsr;
  logic [31:0] lfsr_next;
  logic [31:0] misr;
  logic [31:0] misr_next;
  logic [2:0]  op_idx;
  logic [15:0] count;
  logic        pass_r;

  always_comb begin
    lfsr_next = lfsr >> 1;
    if (lfsr[0]) lfsr_next = lfsr_next ^ 32'h80200003;
  end

  always_comb begin
    misr_next = {misr[30:0], misr[31] ^ misr[21] ^ misr[1] ^ misr[0]}
                ^ alu.ALUOut ^ {31'b0, alu.Zero};
  end

  // Stimulus is always visible, even outside RUN, so the ALU sees stable operands.
  assign alu.A = lfsr;
  assign alu.B = {lfsr[15:0], lfsr[31:16]} ^ 32'h5A5A5A5A;

  always_comb begin
    case (op_idx)
      3'd0:    alu.ALUctl = 4'h0;
      3'd1:    alu.ALUctl = 4'h1;
      3'd2:    alu.ALUctl = 4'h2;
      3'd3:    alu.ALUctl = 4'h6;
      3'd4:    alu.ALUctl = 4'h7;
      3'd5:    alu.ALUctl = 4'hC;
      default: alu.ALUctl = 4'h0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      lfsr   <= LFSR_SEED;
      op_idx <= 3'd0;
      count  <= 16'd0;
      misr   <= 32'd0;
      pass_r <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            state  <= S_RUN;
            lfsr   <= LFSR_SEED;
            op_idx <= 3'd0;
            count  <= 16'd0;
            misr   <= 32'd0;
            pass_r <= 1'b0;
          end
        end
        S_RUN: begin
          // Abort wins over terminal count and leaves the partial signature visible.
          if (abort) begin
            state  <= S_IDLE;
            pass_r <= 1'b0;
          end else begin
            misr <= misr_next;
            if (count == LAST) begin
              state  <= S_DONE;
              pass_r <= (misr_next == GOLDEN_SIG);
            end else begin
              lfsr   <= lfsr_next;
              op_idx <= (op_idx == 3'd5) ? 3'd0 : op_idx + 3'd1;
              count  <= count + 16'd1;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign busy      = (state == S_RUN);
  assign done      = (state == S_DONE);
  assign pass      = pass_r & done;
  assign signature = misr;

endmodule

// File: tb/tb_mips_alu_bist.sv
// tb/tb_mips_alu_bist.sv - scoreboard bench for mips_alu_bist with a behavioural MIPSALU
module tb_mips_alu_bist;

  localparam int          NV   = 8;
  localparam logic [31:0] SEED = 32'hACE12468;

  function automatic logic [31:0] alu_fn(input logic [3:0] c, input logic [31:0] a,
                                         input logic [31:0] b);
    case (c)
      4'h0:    return a & b;
      4'h1:    return a | b;
      4'h2:    return a + b;
      4'h6:    return a - b;
      4'h7:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'hC:    return ~(a | b);
      default: return 32'd0;
    endcase
  endfunction

  // Reference signature, including the optional bit-0 stuck-at-0 fault.
  function automatic logic [31:0] model_sig(input bit stuck);
    logic [31:0] l, m, b, r;
    logic [3:0]  c;
    int          idx;
    l = SEED;
    m = 32'd0;
    idx = 0;
    for (int k = 0; k < NV; k++) begin
      b = {l[15:0], l[31:16]} ^ 32'h5A5A5A5A;
      case (idx)
        0: c = 4'h0;
        1: c = 4'h1;
        2: c = 4'h2;
        3: c = 4'h6;
        4: c = 4'h7;
        default: c = 4'hC;
      endcase
      r = alu_fn(c, l, b);
      if (stuck) r[0] = 1'b0;
      m = {m[30:0], m[31] ^ m[21] ^ m[1] ^ m[0]} ^ r ^ {31'b0, (r == 32'd0)};
      l = l[0] ? ((l >> 1) ^ 32'h80200003) : (l >> 1);
      idx = (idx == 5) ? 0 : idx + 1;
    end
    return m;
  endfunction

  localparam logic [31:0] GOLD = model_sig(1'b0);

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        abort;
  logic        busy;
  logic        done;
  logic        pass;
  logic [31:0] signature;
  logic        stuck0;

  mips_alu_bist_if bus ();

  mips_alu_bist #(.NUM_VECTORS(NV), .LFSR_SEED(SEED), .GOLDEN_SIG(GOLD)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .abort     (abort),
    .alu       (bus.master),
    .busy      (busy),
    .done      (done),
    .pass      (pass),
    .signature (signature)
  );

  always_comb begin
    logic [31:0] r;
    r = alu_fn(bus.ALUctl, bus.A, bus.B);
    if (stuck0) r[0] = 1'b0;
    bus.ALUOut = r;
    bus.Zero   = (r == 32'd0);
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hand-derived operand A sequence from the seed, and the op table order.
  logic [31:0] hand_a   [NV] = '{32'hACE12468, 32'h56709234, 32'h2B38491A, 32'h159C248D,
                                 32'h8AEE1245, 32'hC5570921, 32'hE28B8493, 32'hF165C24A};
  logic [3:0]  hand_ctl [NV] = '{4'h0, 4'h1, 4'h2, 4'h6, 4'h7, 4'hC, 4'h0, 4'h1};

  typedef struct { logic [3:0] c; logic [31:0] a; } vec_t;
  typedef struct { logic [31:0] sig; logic p; } res_t;
  vec_t vq[$];
  res_t rq[$];

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: one expected vector per busy cycle, one expected result per done rise.
  logic done_q = 1'b0;
  vec_t mv;
  res_t mr;
  always @(negedge clk) begin
    if (rst_n && busy) begin
      if (vq.size() == 0) chk("extra_vector", 32'd1, 32'd0);
      else begin
        mv = vq.pop_front();
        chk("vec_ctl", {28'd0, bus.ALUctl}, {28'd0, mv.c});
        chk("vec_a", bus.A, mv.a);
        chk("vec_b", bus.B, {mv.a[15:0], mv.a[31:16]} ^ 32'h5A5A5A5A);
      end
    end
    if (done && !done_q) begin
      if (rq.size() == 0) chk("unexpected_done", 32'd1, 32'd0);
      else begin
        mr = rq.pop_front();
        chk("final_sig", signature, mr.sig);
        chk("final_pass", {31'd0, pass}, {31'd0, mr.p});
      end
    end
    done_q = done;
  end

  task automatic issue_start(input int n);
    @(posedge clk); #1;
    start = 1'b1;
    for (int i = 0; i < n; i++) vq.push_back('{hand_ctl[i], hand_a[i]});
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done();
    for (int i = 0; i < 40 && !done; i++) @(negedge clk);
    chk("done_seen", {31'd0, done}, 32'd1);
    @(posedge clk); #1;
    chk("vq_drained", vq.size(), 32'd0);
    chk("rq_drained", rq.size(), 32'd0);
  endtask

  task automatic golden_run();
    rq.push_back('{GOLD, 1'b1});
    issue_start(NV);
    wait_done();
  endtask

  initial begin
    int hits;
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; stuck0 = 1'b0;
    #12;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_pass", {31'd0, pass}, 32'd0);
    chk("rst_sig", signature, 32'd0);
    chk("rst_a", bus.A, 32'hACE12468);
    chk("rst_b", bus.B, 32'h7E32F6BB);
    chk("rst_ctl", {28'd0, bus.ALUctl}, 32'd0);
    chk("rst_and", bus.ALUOut, 32'h2C202428);
    #1 rst_n = 1'b1;

    golden_run();
    chk("golden_pass", {31'd0, pass}, 32'd1);

    // Abort while in DONE must be ignored.
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    chk("abort_in_done", {31'd0, done}, 32'd1);
    chk("abort_in_done_sig", signature, GOLD);

    golden_run();

    stuck0 = 1'b1;
    rq.push_back('{model_sig(1'b1), 1'b0});
    issue_start(NV);
    wait_done();
    chk("stuck_differs", {31'd0, (signature != GOLD)}, 32'd1);
    stuck0 = 1'b0;

    // Abort during the fourth RUN cycle.
    issue_start(4);
    repeat (3) @(posedge clk);
    #1 abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_done", {31'd0, done}, 32'd0);
    chk("abort_pass", {31'd0, pass}, 32'd0);
    repeat (3) @(posedge clk); #1;
    chk("abort_stays_idle", {30'd0, busy, done}, 32'd0);
    chk("abort_vq", vq.size(), 32'd0);

    golden_run();

    // Asynchronous reset in the middle of a run.
    issue_start(2);
    @(posedge clk);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    chk("mid_rst_done", {31'd0, done}, 32'd0);
    chk("mid_rst_pass", {31'd0, pass}, 32'd0);
    chk("mid_rst_sig", signature, 32'd0);
    chk("mid_rst_a", bus.A, 32'hACE12468);
    chk("mid_rst_ctl", {28'd0, bus.ALUctl}, 32'd0);
    #4 rst_n = 1'b1;
    hits = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (done || busy) hits++;
    end
    chk("no_activity_after_rst", hits, 32'd0);
    chk("mid_rst_vq", vq.size(), 32'd0);

    golden_run();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
